// File: rtl/conv_out_buffer.sv
// Output buffer for the convolution engine: saturates signed accumulator results and queues them in a FIFO.
// Optional build macro CONV_OUT_RELU_EN applies a ReLU to each result before saturation.
module conv_out_buffer #(
    parameter int ACC_SIZE  = 18,
    parameter int OUT_WIDTH = 12,
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid_y,
    output logic                        s_ready_y,
    input  logic signed [ACC_SIZE-1:0]  s_data_in_y,
    output logic                        m_valid_z,
    input  logic                        m_ready_z,
    output logic signed [OUT_WIDTH-1:0] m_data_out_z,
    output logic [PTR_WIDTH:0]          count,
    output logic                        sat_flag
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam int HI_BITS = ACC_SIZE - OUT_WIDTH + 1;

    logic signed [OUT_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 sat_q, sat_d;

    logic                        push;
    logic                        pop;
    logic [HI_BITS-1:0]          hi_bits;
    logic signed [OUT_WIDTH-1:0] sat_val;
    logic                        clipped;

    assign s_ready_y    = (count_q != FULL_COUNT);
    assign m_valid_z    = (count_q != '0);
    assign push         = s_valid_y && s_ready_y;
    assign pop          = m_valid_z && m_ready_z;
    assign m_data_out_z = mem[rptr_q];
    assign count        = count_q;
    assign sat_flag     = sat_q;

    // The value fits when every bit from the output sign bit upward matches;
    // with OUT_WIDTH == ACC_SIZE this slice is one bit and always fits.
    assign hi_bits = s_data_in_y[ACC_SIZE-1:OUT_WIDTH-1];

    // NOTE: every signal written here is given a default first so no latch can be inferred.
    always_comb begin
        sat_val = s_data_in_y[OUT_WIDTH-1:0];
        clipped = 1'b0;
`ifdef CONV_OUT_RELU_EN
        if (s_data_in_y[ACC_SIZE-1]) begin
            sat_val = '0;
        end else if (hi_bits != '0) begin
            sat_val = OUT_MAX;
            clipped = 1'b1;
        end
`else
        if (!s_data_in_y[ACC_SIZE-1] && (hi_bits != '0)) begin
            sat_val = OUT_MAX;
            clipped = 1'b1;
        end else if (s_data_in_y[ACC_SIZE-1] && (hi_bits != '1)) begin
            sat_val = OUT_MIN;
            clipped = 1'b1;
        end
`endif
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
            sat_d  = sat_q | clipped;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= sat_val;
        end
    end

endmodule

// File: tb/tb_conv_out_buffer.sv
// Directed self-checking bench for conv_out_buffer (ACC_SIZE=18, OUT_WIDTH=12, DEPTH=8).
module tb_conv_out_buffer;

    localparam int ACC_SIZE  = 18;
    localparam int OUT_WIDTH = 12;
    localparam int DEPTH     = 8;
    localparam int PTR_WIDTH = $clog2(DEPTH);

`ifdef CONV_OUT_RELU_EN
    localparam int EXP_NEG5000 = 0;
    localparam int EXP_NEG100  = 0;
`else
    localparam int EXP_NEG5000 = -2048;
    localparam int EXP_NEG100  = -100;
`endif

    logic                        clk;
    logic                        reset;
    logic                        s_valid_y;
    logic                        s_ready_y;
    logic signed [ACC_SIZE-1:0]  s_data_in_y;
    logic                        m_valid_z;
    logic                        m_ready_z;
    logic signed [OUT_WIDTH-1:0] m_data_out_z;
    logic [PTR_WIDTH:0]          count;
    logic                        sat_flag;

    int checks = 0;
    int errors = 0;

    conv_out_buffer #(
        .ACC_SIZE (ACC_SIZE),
        .OUT_WIDTH(OUT_WIDTH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid_y   (s_valid_y),
        .s_ready_y   (s_ready_y),
        .s_data_in_y (s_data_in_y),
        .m_valid_z   (m_valid_z),
        .m_ready_z   (m_ready_z),
        .m_data_out_z(m_data_out_z),
        .count       (count),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        s_valid_y   = 1'b0;
        s_data_in_y = '0;
        m_ready_z   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_count", count, 0);
        check("rst_m_valid", m_valid_z, 0);
        check("rst_s_ready", s_ready_y, 1);
        check("rst_sat", sat_flag, 0);

        // Push 5, 7, -3 with downstream stalled.
        s_valid_y = 1'b1;
        s_data_in_y = 5;
        tick();
        check("p1_count", count, 1);
        check("p1_m_valid", m_valid_z, 1);
        s_data_in_y = 7;
        tick();
        check("p2_count", count, 2);
        s_data_in_y = -3;
        tick();
        check("p3_count", count, 3);
        s_valid_y = 1'b0;
        tick();
        check("stall_hold_data", $signed(m_data_out_z), 5);
        check("stall_hold_count", count, 3);

        m_ready_z = 1'b1;
        check("pop_5", $signed(m_data_out_z), 5);
        tick();
        check("pop_7", $signed(m_data_out_z), 7);
        tick();
        check("pop_m3", $signed(m_data_out_z), -3);
        tick();
        check("drain_count", count, 0);
        check("drain_m_valid", m_valid_z, 0);
        m_ready_z = 1'b0;

        // Fill to DEPTH; a ninth value must wait for space.
        s_valid_y = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data_in_y = 18'(100 + i);
            tick();
        end
        check("full_count", count, DEPTH);
        check("full_s_ready", s_ready_y, 0);
        s_data_in_y = 99;
        tick();
        check("full_reject_count", count, DEPTH);
        m_ready_z = 1'b1;
        check("full_ready_during_pop", s_ready_y, 0);
        tick();
        m_ready_z = 1'b0;
        check("after_pop_count", count, DEPTH - 1);
        check("after_pop_s_ready", s_ready_y, 1);
        tick();
        s_valid_y = 1'b0;
        check("accept99_count", count, DEPTH);
        m_ready_z = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            check("fill_order", $signed(m_data_out_z), 100 + i);
            tick();
        end
        check("fill_last_99", $signed(m_data_out_z), 99);
        tick();
        check("fill_drain_count", count, 0);

        // Streaming 0..19 with both sides ready; pointers wrap.
        s_valid_y = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data_in_y = 18'(i);
            if (i > 0) begin
                check("stream_data", $signed(m_data_out_z), i - 1);
                check("stream_count", count, 1);
            end
            tick();
        end
        s_valid_y = 1'b0;
        check("stream_last", $signed(m_data_out_z), 19);
        tick();
        check("stream_empty", count, 0);
        m_ready_z = 1'b0;

        // Saturation.
        check("sat_before", sat_flag, 0);
        s_valid_y = 1'b1;
        s_data_in_y = 2047;
        tick();
        check("sat_after_2047", sat_flag, 0);
        s_data_in_y = 3000;
        tick();
        check("sat_after_3000", sat_flag, 1);
        s_data_in_y = -5000;
        tick();
        s_data_in_y = -100;
        tick();
        s_valid_y = 1'b0;
        check("sat_count", count, 4);
        m_ready_z = 1'b1;
        check("sat_out_2047", $signed(m_data_out_z), 2047);
        tick();
        check("sat_out_3000", $signed(m_data_out_z), 2047);
        tick();
        check("sat_out_m5000", $signed(m_data_out_z), EXP_NEG5000);
        tick();
        check("sat_out_m100", $signed(m_data_out_z), EXP_NEG100);
        tick();
        check("sat_sticky", sat_flag, 1);
        m_ready_z = 1'b0;

        // Reset with four entries queued.
        s_valid_y = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_data_in_y = 18'(i);
            tick();
        end
        s_valid_y = 1'b0;
        check("pre_reset_count", count, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_m_valid", m_valid_z, 0);
        check("mid_rst_sat", sat_flag, 0);
        check("mid_rst_s_ready", s_ready_y, 1);

        // -100 never sets the sticky flag; 4000 clips to 2047 and does.
        s_valid_y = 1'b1;
        s_data_in_y = -100;
        tick();
        check("neg100_sat", sat_flag, 0);
        s_data_in_y = 4000;
        tick();
        s_valid_y = 1'b0;
        check("p4000_sat", sat_flag, 1);
        m_ready_z = 1'b1;
        check("neg100_out", $signed(m_data_out_z), EXP_NEG100);
        tick();
        check("p4000_out", $signed(m_data_out_z), 2047);
        tick();
        check("final_empty", count, 0);
        m_ready_z = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_out_buffer.md
Name: conv_out_buffer

Overview:
- Downstream stage of the convolution engine.
- Accepts signed accumulator results over a valid/ready handshake and saturates each from ACC_SIZE to OUT_WIDTH bits.
- Stores results in a DEPTH-entry FIFO and presents them to the next master over a second valid/ready handshake.
- Decouples the convolution engine from output back-pressure, so the engine never stalls while buffer space remains.

Parameters:
- ACC_SIZE, 18, width of incoming signed accumulator result.
- OUT_WIDTH, 12, width of outgoing signed saturated result; must be <= ACC_SIZE.
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- PTR_WIDTH, $clog2(DEPTH), read/write pointer width (derived).

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- s_valid_y, input, 1, upstream result valid.
- s_ready_y, output, 1, buffer can accept a result.
- s_data_in_y, input, ACC_SIZE signed, upstream result.
- m_valid_z, output, 1, buffered result available.
- m_ready_z, input, 1, downstream accepts result.
- m_data_out_z, output, OUT_WIDTH signed, head-of-FIFO result.
- count, output, PTR_WIDTH+1, current occupancy 0..DEPTH.
- sat_flag, output, 1, sticky: at least one accepted result was saturated.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - write pointer, read pointer and count = 0.
  - m_valid_z = 0, s_ready_y = 1, sat_flag = 0.
  - m_data_out_z is don't-care while m_valid_z = 0.
  - Storage contents are not reset.
- Handshake rules:
  - s_ready_y = (count != DEPTH), purely from registered count.
  - m_valid_z = (count != 0).
  - push = s_valid_y && s_ready_y; pop = m_valid_z && m_ready_z.
- Push/pop updates:
  - Push: writes the saturated value to mem[wptr]; wptr increments modulo DEPTH (natural wrap).
  - Pop: rptr increments modulo DEPTH.
  - count next = count + push - pop; simultaneous push and pop leaves count unchanged.
- Full: s_ready_y = 0 even if pop occurs in the same cycle; no combinational ready path from m_ready_z. Space reappears the cycle after the pop.
- Empty: m_valid_z = 0; a push into an empty FIFO makes m_valid_z = 1 the next cycle, giving 1-cycle minimum latency. No same-cycle bypass.
- m_data_out_z = mem[rptr], combinational read of registered storage. It must hold stable while m_valid_z && !m_ready_z.
- Saturation, applied at the input before storage:
  - If s_data_in_y > 2^(OUT_WIDTH-1)-1, store 2^(OUT_WIDTH-1)-1.
  - If s_data_in_y < -2^(OUT_WIDTH-1), store -2^(OUT_WIDTH-1).
  - Otherwise store the low OUT_WIDTH bits (sign preserved).
  - If OUT_WIDTH == ACC_SIZE, pass through unchanged.
- sat_flag: set on the cycle after any push whose value clipped; cleared only by reset.
- Reset mid-operation: all contents discarded; the FIFO is empty on the next cycle regardless of in-flight handshakes.
- Upstream inputs are ignored while s_ready_y = 0. Data under a non-accepted valid is not captured.

Optional Feature:
- Macro: CONV_OUT_RELU_EN.
- Defined: a ReLU is applied before saturation. Negative s_data_in_y is stored as 0, and a negative input never sets sat_flag; positive values saturate as normal.
- Undefined: no ReLU; signed saturation only, as described above.

Test Plan:
- Reset then push 5, 7, -3 with m_ready_z = 0:
  - count goes 1, 2, 3; m_valid_z rises the cycle after the first push.
  - Then m_ready_z = 1 pops 5, 7, -3 in order; count returns to 0 and m_valid_z = 0.
- DEPTH = 8 with 8 pushes and m_ready_z = 0:
  - s_ready_y = 0 and count = 8; a ninth valid value, 99, is not stored.
  - Hold s_valid_y and pop once: s_ready_y = 1 one cycle later, then 99 is accepted.
- Continuous s_valid_y and m_ready_z for 20 values 0..19:
  - Pointer wrap occurs; outputs are 0..19 in order with no loss or duplication; count stays at 1 in steady state.
- Saturation with ACC_SIZE = 18, OUT_WIDTH = 12:
  - Input 3000 -> 2047; input -5000 -> -2048; input 2047 -> 2047.
  - sat_flag = 0 after the first pushes of 2047 alone; sat_flag = 1 after the push of 3000 and stays 1.
- Reset asserted with count = 4:
  - Next cycle: count = 0, m_valid_z = 0, sat_flag = 0, s_ready_y = 1.
- Compiled with CONV_OUT_RELU_EN:
  - Input -100 -> 0 with sat_flag unchanged; input 4000 -> 2047 with sat_flag = 1.
